uart_output: RTL

Output stage of the Brainfuck processor: consumes the CPU's `data_out` / `data_out_en` byte stream and buffers it in a small synchronous FIFO. It serialises the bytes onto a single UART TX line (8N1 framing, LSB first).
- The CPU cannot stall, so the block never back-pressures it.
- Bytes arriving while the FIFO is full are dropped and recorded in a sticky overflow flag.

---
 rtl/uart_output_pkg.sv | 20 ++
 rtl/byte_fifo.sv | 67 ++++++
 rtl/uart_output.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_output_pkg.sv
// Shared definitions for the UART output stage: FSM state encoding and 8N1 framing levels.
package uart_output_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

    // Index width that never collapses to zero for tiny parameter values.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word fall-through FIFO; a push on a full FIFO is accepted only alongside a pop.
module byte_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_d;
    logic                  do_wr;
    logic                  do_rd;

    always_comb begin
        do_rd   = rd_en && !empty;
        do_wr   = wr_en && (!full || do_rd);
        count_d = count;
        if (do_wr && !do_rd) begin
            count_d = count + CNT_W'(1);
        end else if (!do_wr && do_rd) begin
            count_d = count - CNT_W'(1);
        end
    end

    // Flags are registered from the next count so they line up with the pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            count <= count_d;
            full  <= (count_d == CNT_W'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_output.sv
// UART transmit stage: buffers CPU output bytes and serialises them as 8N1 frames, LSB first.
module uart_output
    import uart_output_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned FADDR_WIDTH  = 4,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  full,
    output logic                  overflow
);

    localparam int unsigned CNT_W = idx_width(CLKS_PER_BIT);
    localparam int unsigned BIT_W = idx_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_WIDTH - 1);

    uart_state_e           state_q;
    uart_state_e           state_d;
    logic [CNT_W-1:0]      baud_q;
    logic [CNT_W-1:0]      baud_d;
    logic [BIT_W-1:0]      bit_q;
    logic [BIT_W-1:0]      bit_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic                  tx_d;
    logic                  busy_d;
    logic                  overflow_d;
    logic                  pop;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_empty;

    byte_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (FADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (data_in_en),
        .wr_data (data_in),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (full),
        .empty   (fifo_empty)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx;
        pop        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                tx_d = LINE_IDLE;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    baud_d  = BAUD_RELOAD;
                    tx_d    = START_BIT;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_RELOAD;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == LAST_BIT) begin
                        tx_d    = STOP_BIT;
                        state_d = ST_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BIT_W'(1);
                        tx_d    = shift_d[0];
                    end
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_q == '0) begin
                    // A waiting byte starts its frame immediately, keeping frames contiguous.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        baud_d  = BAUD_RELOAD;
                        tx_d    = START_BIT;
                        state_d = ST_START;
                    end else begin
                        tx_d    = LINE_IDLE;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
            default: begin
                tx_d    = LINE_IDLE;
                state_d = ST_IDLE;
            end
        endcase

        // Without a pop the FIFO stays non-empty, or becomes so only through this cycle's push.
        busy_d     = (state_d != ST_IDLE) || !fifo_empty || data_in_en;
        overflow_d = overflow || (data_in_en && full && !pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx       <= LINE_IDLE;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx       <= tx_d;
            busy     <= busy_d;
            overflow <= overflow_d;
        end
    end

endmodule
